xsz_dn_split: RTL and testbench

XSZ_DN_SPLIT -- requirements
Module: xsz_dn_split

---
 rtl/xsz_dn_split_if.sv | 30 +++
 rtl/xsz_dn_split.sv | 103 ++++++++++
 tb/tb_xsz_dn_split.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xsz_dn_split_if.sv
// Wide request and narrow beat channels of the downsizer.
// The slave modport is the wide side and the master modport is the narrow side.
interface xsz_dn_split_if #(
  parameter int A  = 19,
  parameter int DI = 64,
  parameter int DO = 32
) ();
  logic            s_vld;
  logic            s_rdy;
  logic [A-1:0]    s_adr;
  logic [DI-1:0]   s_dat;
  logic [DI/8-1:0] s_strb;

  logic            m_vld;
  logic            m_rdy;
  logic [A-1:0]    m_adr;
  logic [DO-1:0]   m_dat;
  logic [DO/8-1:0] m_strb;
  logic            m_last;

  modport slave (
    input  s_vld, s_adr, s_dat, s_strb,
    output s_rdy
  );

  modport master (
    output m_vld, m_adr, m_dat, m_strb, m_last,
    input  m_rdy
  );
endinterface

// File: rtl/xsz_dn_split.sv
// Buffered downsizer: one wide request becomes narrow beats, from the
// addressed lane up to the top lane, with registered beat outputs.
module xsz_dn_split #(
  parameter int A  = 19,
  parameter int DI = 64,
  parameter int DO = 32
) (
  input  logic             clk,
  input  logic             rstn,
  xsz_dn_split_if.slave    s,
  xsz_dn_split_if.master   m
);
  localparam int R    = DI / DO;
  localparam int SO   = DO / 8;
  localparam int SI   = DI / 8;
  localparam int LIDX = $clog2(SO);
  localparam int HIDX = $clog2(SI) - 1;
  localparam int LW   = $clog2(R);
  localparam logic [A-1:0] LOMASK = A'(SI - 1);
  localparam logic [LW-1:0] TOP = LW'(R - 1);

  typedef enum logic { IDLE, BUSY } state_e;

  state_e          state_q, state_d;
  logic [A-1:0]    adr_q, adr_d;
  logic [DI-1:0]   dat_q, dat_d;
  logic [SI-1:0]   strb_q, strb_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [A-1:0]    oadr_q, oadr_d;
  logic [DO-1:0]   odat_q, odat_d;
  logic [SO-1:0]   ostrb_q, ostrb_d;
  logic            olast_q, olast_d;
  logic            hs;
  logic            acc;

  assign m.m_vld  = (state_q == BUSY);
  assign m.m_adr  = oadr_q;
  assign m.m_dat  = odat_q;
  assign m.m_strb = ostrb_q;
  assign m.m_last = olast_q;

  assign hs      = m.m_vld & m.m_rdy;
  assign s.s_rdy = (state_q == IDLE) | (hs & olast_q);
  assign acc     = s.s_vld & s.s_rdy;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    strb_d  = strb_q;
    lane_d  = lane_q;
    oadr_d  = oadr_q;
    odat_d  = odat_q;
    ostrb_d = ostrb_q;
    olast_d = olast_q;
    // A new accept wins over retiring the last beat, so no bubble.
    if (acc) begin
      state_d = BUSY;
      adr_d   = s.s_adr;
      dat_d   = s.s_dat;
      strb_d  = s.s_strb;
      lane_d  = s.s_adr[HIDX:LIDX];
      oadr_d  = s.s_adr;
      odat_d  = s.s_dat[lane_d*DO +: DO];
      ostrb_d = s.s_strb[lane_d*SO +: SO];
      olast_d = (lane_d == TOP);
    end else if (hs) begin
      if (olast_q) begin
        state_d = IDLE;
      end else begin
        lane_d  = lane_q + 1'b1;
        oadr_d  = (adr_q & ~LOMASK) | (A'(lane_d) << LIDX);
        odat_d  = dat_q[lane_d*DO +: DO];
        ostrb_d = strb_q[lane_d*SO +: SO];
        olast_d = (lane_d == TOP);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      strb_q  <= '0;
      lane_q  <= '0;
      oadr_q  <= '0;
      odat_q  <= '0;
      ostrb_q <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      strb_q  <= strb_d;
      lane_q  <= lane_d;
      oadr_q  <= oadr_d;
      odat_q  <= odat_d;
      ostrb_q <= ostrb_d;
      olast_q <= olast_d;
    end
  end
endmodule

// File: tb/tb_xsz_dn_split.sv
// Bench for xsz_dn_split: directed cases plus random traffic
// checked against a beat-queue model of the split rules.
module tb_xsz_dn_split;
  localparam int A  = 19;
  localparam int DI = 64;
  localparam int DO = 32;
  localparam int R  = DI / DO;
  localparam int SO = DO / 8;
  localparam int SI = DI / 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  xsz_dn_split_if #(.A(A), .DI(DI), .DO(DO)) if1 ();
  xsz_dn_split_if #(.A(A), .DI(128), .DO(32)) if2 ();

  xsz_dn_split #(.A(A), .DI(DI), .DO(DO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (if1),
    .m    (if1)
  );

  xsz_dn_split #(.A(A), .DI(128), .DO(32)) dut2 (
    .clk  (clk),
    .rstn (rstn),
    .s    (if2),
    .m    (if2)
  );

  typedef struct {
    logic [A-1:0]  adr;
    logic [DO-1:0] dat;
    logic [SO-1:0] strb;
    logic          last;
  } beat_t;

  beat_t q[$];
  bit    mon_en = 1'b0;
  int    n_vec  = 0;
  int    n_err  = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_push(input logic [A-1:0] a,
                                     input logic [DI-1:0] d,
                                     input logic [SI-1:0] s);
    int    idx0;
    beat_t b;
    idx0 = (int'(a) % SI) / SO;
    for (int i = idx0; i < R; i++) begin
      b.adr  = (i == idx0) ? a : ((a & ~A'(SI - 1)) | A'(i * SO));
      b.dat  = DO'(d >> (i * DO));
      b.strb = SO'(s >> (i * SO));
      b.last = (i == R - 1);
      q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin : mon
    bit busy;
    bit esr;
    if (rstn && mon_en) begin
      busy = (q.size() != 0);
      chk("m_vld", if1.m_vld, busy);
      if (busy) begin
        chk("m_adr", if1.m_adr, q[0].adr);
        chk("m_dat", if1.m_dat, q[0].dat);
        chk("m_strb", if1.m_strb, q[0].strb);
        chk("m_last", if1.m_last, q[0].last);
      end
      esr = !busy || (if1.m_rdy && q[0].last);
      chk("s_rdy", if1.s_rdy, esr);
      if (busy && if1.m_rdy) void'(q.pop_front());
      if (if1.s_vld && esr) model_push(if1.s_adr, if1.s_dat, if1.s_strb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [A-1:0] a, input logic [DI-1:0] d,
                     input logic [SI-1:0] s);
    if1.s_vld  = 1'b1;
    if1.s_adr  = a;
    if1.s_dat  = d;
    if1.s_strb = s;
  endtask

  task automatic aligned_seq();
    if1.m_rdy = 1'b1;
    put(19'h00100, 64'h11112222_33334444, 8'hFF);
    tick();
    if1.s_vld = 1'b0;
    @(negedge clk);
    chk("al_b1_adr", if1.m_adr, 19'h00100);
    chk("al_b1_dat", if1.m_dat, 32'h33334444);
    chk("al_b1_strb", if1.m_strb, 4'hF);
    chk("al_b1_last", if1.m_last, 1'b0);
    tick();
    @(negedge clk);
    chk("al_b2_adr", if1.m_adr, 19'h00104);
    chk("al_b2_dat", if1.m_dat, 32'h11112222);
    chk("al_b2_last", if1.m_last, 1'b1);
    chk("al_b2_srdy", if1.s_rdy, 1'b1);
    tick();
    @(negedge clk);
    chk("al_idle", if1.m_vld, 1'b0);
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    if1.s_vld = 1'b0; if1.s_adr = '0; if1.s_dat = '0; if1.s_strb = '0;
    if1.m_rdy = 1'b0;
    if2.s_vld = 1'b0; if2.s_adr = '0; if2.s_dat = '0; if2.s_strb = '0;
    if2.m_rdy = 1'b1;
    #1;
    chk("rst_srdy", if1.s_rdy, 1'b1);
    chk("rst_mvld", if1.m_vld, 1'b0);
    chk("rst_madr", if1.m_adr, '0);
    chk("rst_mdat", if1.m_dat, '0);
    chk("rst_mstrb", if1.m_strb, '0);
    chk("rst_mlast", if1.m_last, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;
    tick();

    aligned_seq();

    put(19'h00106, 64'h11112222_33334444, 8'hC0);
    tick();
    if1.s_vld = 1'b0;
    @(negedge clk);
    chk("ua_adr", if1.m_adr, 19'h00106);
    chk("ua_dat", if1.m_dat, 32'h11112222);
    chk("ua_strb", if1.m_strb, 4'hC);
    chk("ua_last", if1.m_last, 1'b1);
    tick();
    tick();

    put(19'h00100, 64'h11112222_33334444, 8'hFF);
    tick();
    if1.s_vld = 1'b0;
    if1.m_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_adr", if1.m_adr, 19'h00100);
      chk("bp_dat", if1.m_dat, 32'h33334444);
      chk("bp_srdy", if1.s_rdy, 1'b0);
      tick();
    end
    if1.m_rdy = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_b2_adr", if1.m_adr, 19'h00104);
    chk("bp_b2_last", if1.m_last, 1'b1);
    tick();
    tick();

    put(19'h00100, 64'h11112222_33334444, 8'hFF);
    tick();
    put(19'h00200, 64'hAAAABBBB_CCCCDDDD, 8'h0F);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_vld", if1.m_vld, 1'b1);
      chk("b2b_last", if1.m_last, k[0]);
      tick();
      if (k == 1) if1.s_vld = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle", if1.m_vld, 1'b0);
    tick();

    if2.s_vld  = 1'b1;
    if2.s_adr  = 19'h00208;
    if2.s_dat  = 128'h44444444_33333333_22222222_11111111;
    if2.s_strb = 16'hFFFF;
    tick();
    if2.s_vld = 1'b0;
    @(negedge clk);
    chk("w_b1_adr", if2.m_adr, 19'h00208);
    chk("w_b1_dat", if2.m_dat, 32'h33333333);
    chk("w_b1_last", if2.m_last, 1'b0);
    tick();
    @(negedge clk);
    chk("w_b2_adr", if2.m_adr, 19'h0020C);
    chk("w_b2_dat", if2.m_dat, 32'h44444444);
    chk("w_b2_last", if2.m_last, 1'b1);
    tick();
    @(negedge clk);
    chk("w_idle", if2.m_vld, 1'b0);
    tick();

    put(19'h00100, 64'h11112222_33334444, 8'hFF);
    tick();
    if1.s_vld = 1'b0;
    @(negedge clk);
    chk("ro_pre_vld", if1.m_vld, 1'b1);
    #2;
    rstn = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("ro_vld", if1.m_vld, 1'b0);
    chk("ro_srdy", if1.s_rdy, 1'b1);
    chk("ro_dat", if1.m_dat, '0);
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;
    tick();
    aligned_seq();

    for (int k = 0; k < 600; k++) begin
      if1.s_vld  = 1'($urandom_range(0, 1));
      if1.s_adr  = A'($urandom);
      if1.s_dat  = {$urandom, $urandom};
      if1.s_strb = SI'($urandom);
      if1.m_rdy  = ($urandom_range(0, 3) != 0);
      tick();
    end
    if1.s_vld = 1'b0;
    if1.m_rdy = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    chk("drain", q.size(), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
